// File: rtl/h80_uart_tx_io.sv
// h80 bus UART transmitter: TX FIFO, STATUS/DIV registers, 8N1 serializer on uart_txp.
// state | meaning: IDLE line high, waiting for a byte; START low bit; DATA 8 bits LSB first; STOP high bit.
module h80_uart_tx_io #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int FIFO_DEPTH = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd234,
    parameter bit BLOCKING_WRITE = 1'b1,
    parameter logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ_B = BUS_CMD_WIDTH'(1),
    parameter logic [BUS_CMD_WIDTH-1:0] BUS_CMD_WRITE_B = BUS_CMD_WIDTH'(2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce_n,
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data,
    output logic                      wait_n,
    output logic                      uart_txp
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [BUS_ADDR_WIDTH-1:0] off;
    logic sel, is_rd, is_wr, hit_tx, hit_st, hit_div;
    logic done, wr_act, push, drop, pop;
    logic full, empty, busy, overflow;
    logic [7:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    logic [15:0] div;
    logic [BUS_DATA_WIDTH-1:0] rdata;

    state_t state;
    logic [15:0] bitdiv, cnt;
    logic [7:0] shreg;
    logic [2:0] bitidx;

    assign off     = addr - BASE_ADDR;
    assign sel     = !ce_n && (off < BUS_ADDR_WIDTH'(3));
    assign is_rd   = (cmd == BUS_CMD_READ_B);
    assign is_wr   = (cmd == BUS_CMD_WRITE_B);
    assign hit_tx  = (off == BUS_ADDR_WIDTH'(0));
    assign hit_st  = (off == BUS_ADDR_WIDTH'(1));
    assign hit_div = (off == BUS_ADDR_WIDTH'(2));

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign busy  = !empty || (state != S_IDLE);

    // Stall only a blocking TXDATA write into a full FIFO; full comes from registered count.
    assign wait_n = !(sel && is_wr && hit_tx && full && BLOCKING_WRITE && !done);
    assign wr_act = sel && is_wr && wait_n && !done;
    assign push   = wr_act && hit_tx && !full;
    assign drop   = wr_act && hit_tx && full;
    assign pop    = !empty && ((state == S_IDLE) || (state == S_STOP && cnt == 16'd0));

    always_comb begin
        rdata = '0;
        if (hit_st)
            rdata[15:0] = {8'(count), 4'b0000, overflow, busy, empty, full};
        else if (hit_div)
            rdata[15:0] = div;
    end

    assign data = (sel && is_rd) ? rdata : 'z;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= DEFAULT_DIV;
            done     <= 1'b0;
        end else begin
            done <= ce_n ? 1'b0 : (done | wr_act);
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (wr_act && hit_st && data[3])
                overflow <= 1'b0;
            if (wr_act && hit_div)
                div <= (data[15:0] == 16'd0) ? 16'd1 : data[15:0];
        end
    end

    // Divisor is sampled at pop so a DIV write never disturbs a frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bitdiv   <= DEFAULT_DIV;
            cnt      <= 16'd0;
            shreg    <= 8'd0;
            bitidx   <= 3'd0;
            uart_txp <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state    <= S_START;
                        uart_txp <= 1'b0;
                        shreg    <= mem[rptr];
                        bitdiv   <= div;
                        cnt      <= div - 16'd1;
                    end
                end
                S_START: begin
                    if (cnt == 16'd0) begin
                        state    <= S_DATA;
                        uart_txp <= shreg[0];
                        shreg    <= shreg >> 1;
                        bitidx   <= 3'd0;
                        cnt      <= bitdiv - 16'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == 16'd0) begin
                        cnt <= bitdiv - 16'd1;
                        if (bitidx == 3'd7) begin
                            state    <= S_STOP;
                            uart_txp <= 1'b1;
                        end else begin
                            bitidx   <= bitidx + 3'd1;
                            uart_txp <= shreg[0];
                            shreg    <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == 16'd0) begin
                        if (pop) begin
                            state    <= S_START;
                            uart_txp <= 1'b0;
                            shreg    <= mem[rptr];
                            bitdiv   <= div;
                            cnt      <= div - 16'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_h80_uart_tx_io.sv
// Bench for h80_uart_tx_io: blocking instance at 0x0000 and dropping instance at 0x0010 on one bus.
// Expected frames are queued at write time; a line monitor checks them against the waveform rule.
module tb_h80_uart_tx_io;
    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_RD   = 3'd1;
    localparam logic [2:0] CMD_WR   = 3'd2;
    localparam logic [15:0] BASE_B  = 16'h0010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce_n = 1'b1;
    logic [15:0] addr = '0;
    logic [2:0] cmd = CMD_IDLE;
    logic [15:0] drv = '0;
    logic oe = 1'b0;
    wire [15:0] data;
    logic wait_a, wait_b, txp_a, txp_b;
    wire wait_n = wait_a & wait_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_seen = 0;

    typedef struct {
        logic [7:0] b;
        int div;
        bit b2b;
    } exp_t;
    exp_t exp_q[$];

    assign data = oe ? drv : 'z;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    h80_uart_tx_io #(.FIFO_DEPTH(4), .BLOCKING_WRITE(1'b1), .BASE_ADDR(16'h0000)) dut_a (
        .clk(clk), .reset(reset), .ce_n(ce_n), .addr(addr), .cmd(cmd),
        .data(data), .wait_n(wait_a), .uart_txp(txp_a)
    );

    h80_uart_tx_io #(.FIFO_DEPTH(4), .BLOCKING_WRITE(1'b0), .BASE_ADDR(BASE_B),
                     .DEFAULT_DIV(16'd50)) dut_b (
        .clk(clk), .reset(reset), .ce_n(ce_n), .addr(addr), .cmd(cmd),
        .data(data), .wait_n(wait_b), .uart_txp(txp_b)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // 8N1 line level k clocks into a frame of byte b at div clocks per bit.
    function automatic logic frame_bit(logic [7:0] b, int div, int k);
        int n;
        n = k / div;
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return b[n-1];
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [15:0] v, input int hold,
                             output int stalls);
        bit w;
        stalls = 0;
        @(posedge clk); #1;
        ce_n = 1'b0; addr = a; cmd = CMD_WR; drv = v; oe = 1'b1;
        forever begin
            @(negedge clk);
            w = wait_n;
            @(posedge clk);
            if (w) break;
            stalls++;
            if (stalls > 2000) begin
                chk("write_stall_timeout", stalls, 0);
                break;
            end
        end
        repeat (hold - 1) @(posedge clk);
        #1;
        ce_n = 1'b1; cmd = CMD_IDLE; oe = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        @(posedge clk); #1;
        ce_n = 1'b0; addr = a; cmd = CMD_RD; oe = 1'b0;
        @(negedge clk);
        v = data;
        @(posedge clk); #1;
        ce_n = 1'b1; cmd = CMD_IDLE;
    endtask

    task automatic send_a(input logic [7:0] b, input int div, input bit b2b);
        int s;
        exp_t e;
        e.b = b; e.div = div; e.b2b = b2b;
        exp_q.push_back(e);
        bus_write(16'h0000, {8'h00, b}, 1, s);
    endtask

    task automatic wait_idle_a(input string name);
        logic [15:0] v;
        int n;
        n = 0;
        v = 16'hffff;
        while (v[2] && n < 1500) begin
            bus_read(16'h0001, v);
            n++;
        end
        repeat (3) @(posedge clk);
        chk({name, "_idle_in_time"}, int'(v[2]), 0);
        chk({name, "_frames_pending"}, exp_q.size(), 0);
        bus_read(16'h0001, v);
        chk({name, "_status_idle"}, v, 16'h0002);
    endtask

    // Line monitor: each low sample from idle starts a frame that must match the queue head.
    initial begin : monitor
        int prev_end;
        int start;
        int bad;
        bit aborted;
        exp_t e;
        prev_end = -100;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_end = -100;
                continue;
            end
            if (txp_a !== 1'b0) continue;
            frames_seen++;
            start = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_frame_start", 1, 0);
                for (int k = 0; k < 5000 && txp_a == 1'b0; k++) @(negedge clk);
                continue;
            end
            e = exp_q.pop_front();
            if (e.b2b)
                chk($sformatf("gap_before_%02h", e.b), start, prev_end + 1);
            bad = 0;
            aborted = 1'b0;
            for (int k = 0; k < 10 * e.div; k++) begin
                if (k > 0) @(negedge clk);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
                if (txp_a !== frame_bit(e.b, e.div, k)) bad++;
            end
            if (aborted) begin
                exp_q.delete();
                prev_end = -100;
                continue;
            end
            chk($sformatf("frame_%02h_div%0d_bad_samples", e.b, e.div), bad, 0);
            prev_end = cyc;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] v;
        int s, stall_sum, seen0;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, decode and bus release.
        bus_read(16'h0001, v); chk("rst_status", v, 16'h0002);
        bus_read(16'h0002, v); chk("rst_div", v, 16'd234);
        bus_read(16'h0000, v); chk("txdata_reads_zero", v, 16'h0000);
        bus_read(BASE_B + 16'h0001, v); chk("rst_status_b", v, 16'h0002);
        chk("rst_txp", int'(txp_a), 1);
        @(posedge clk); #1;
        ce_n = 1'b1; addr = 16'h0001; cmd = CMD_RD; drv = 16'h0000; oe = 1'b1;
        @(negedge clk); chk("no_drive_ce_high", data, 16'h0000);
        @(posedge clk); #1;
        ce_n = 1'b0; addr = 16'h0005;
        @(negedge clk);
        chk("no_drive_out_of_range", data, 16'h0000);
        chk("no_wait_out_of_range", int'(wait_n), 1);
        @(posedge clk); #1;
        ce_n = 1'b1; cmd = CMD_IDLE; oe = 1'b0;

        // Single frame, write held for three cycles.
        bus_write(16'h0002, 16'd4, 1, s);
        bus_read(16'h0002, v); chk("div_4", v, 16'd4);
        begin
            exp_t e;
            e.b = 8'h55; e.div = 4; e.b2b = 1'b0;
            exp_q.push_back(e);
        end
        bus_write(16'h0000, 16'h0055, 3, s);
        bus_read(16'h0001, v); chk("status_busy_in_frame", v, 16'h0006);
        wait_idle_a("t2");

        // FIFO fill with blocking stall, back-to-back frames.
        bus_write(16'h0002, 16'd8, 1, s);
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            b = 8'($urandom_range(0, 255));
            e.b = b; e.div = 8; e.b2b = (i != 0);
            exp_q.push_back(e);
            bus_write(16'h0000, {8'h00, b}, 1, s);
            if (i < 5) chk($sformatf("no_stall_write%0d", i), s, 0);
            else chk("stall_write5_in_range", int'(s >= 60 && s <= 80), 1);
        end
        wait_idle_a("t3");

        // Non-blocking instance: overflow drops bytes without stalling.
        stall_sum = 0;
        for (int i = 0; i < 7; i++) begin
            bus_write(BASE_B, 16'($urandom_range(0, 255)), 1, s);
            stall_sum += s;
        end
        chk("b_no_stall", stall_sum, 0);
        bus_read(BASE_B + 16'h0001, v); chk("b_status_overflow", v, 16'h040D);
        bus_write(BASE_B + 16'h0001, 16'h0008, 1, s);
        bus_read(BASE_B + 16'h0001, v); chk("b_status_cleared", v, 16'h0405);

        // DIV=0 stored as 1; mid-frame DIV write only affects the next frame.
        bus_write(16'h0002, 16'd0, 1, s);
        bus_read(16'h0002, v); chk("div_zero_as_one", v, 16'd1);
        send_a(8'($urandom_range(0, 255)), 1, 1'b0);
        bus_write(16'h0002, 16'd20, 1, s);
        send_a(8'($urandom_range(0, 255)), 20, 1'b1);
        wait_idle_a("t5");

        // Reset mid-frame discards the serializer and the queue.
        bus_write(16'h0002, 16'd8, 1, s);
        for (int i = 0; i < 4; i++)
            send_a(8'($urandom_range(0, 255)), 8, i != 0);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("txp_after_reset", int'(txp_a), 1);
        @(posedge clk); #1 reset = 1'b0;
        bus_read(16'h0001, v); chk("status_after_reset", v, 16'h0002);
        seen0 = frames_seen;
        repeat (300) @(posedge clk);
        chk("no_frames_after_reset", frames_seen - seen0, 0);
        bus_read(16'h0001, v); chk("status_end", v, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
